// File: rtl/nbbpu_pkg.sv
// rtl/nbbpu_pkg.sv - shared opcode, controller-state and decode-class types for the NBBPU
//
// Purpose: single home for the 4-bit opcode map, the controller state
// encoding and the instruction class produced by the decoder, so the
// controller, the ALU and benches agree on one set of names.
// Ports: none (package).

package nbbpu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_IOR = 4'h3,
    OP_XOR = 4'h4,
    OP_SHR = 4'h5,
    OP_SHL = 4'h6,
    OP_CMP = 4'h7,
    OP_JMP = 4'h8,
    OP_BRZ = 4'h9,
    OP_BRN = 4'hA,
    OP_HLT = 4'hB,
    OP_LOD = 4'hC,
    OP_STR = 4'hD,
    OP_SEL = 4'hE,
    OP_SEU = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ST_START   = 3'd0,
    ST_FETCH   = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEMORY  = 3'd3,
    ST_HALT    = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    CL_ALU    = 3'd0,
    CL_SET    = 3'd1,
    CL_BRANCH = 3'd2,
    CL_LOAD   = 3'd3,
    CL_STORE  = 3'd4,
    CL_HALT   = 3'd5
  } class_e;

  // The eight ALU opcodes occupy the bottom half of the opcode space.
  function automatic logic is_alu_op(input opcode_e op);
    return op <= OP_CMP;
  endfunction

endpackage

// File: rtl/nbbpu_decode.sv
// rtl/nbbpu_decode.sv - combinational opcode-to-control decode for the NBBPU controller
//
// Purpose: turns the registered opcode (plus the datapath branch flags) into
// an instruction class and the register-file / PC-select controls. The
// controller decides in which state and cycle these are allowed out.
// Ports:
//   opcode          in  4  opcode field of the instruction register
//   branch_zero     in  1  operand register == 0
//   branch_negative in  1  operand register bit 15
//   op_class        out    alu/set/branch/load/store/halt
//   wr_lower        out 1  write register bits [7:0]
//   wr_upper        out 1  write register bits [15:8]
//   reg_set         out 1  immediate byte selected as register input
//   pc_select       out 1  take jump target instead of PC+2

module nbbpu_decode
  import nbbpu_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       branch_zero,
  input  logic       branch_negative,
  output class_e     op_class,
  output logic       wr_lower,
  output logic       wr_upper,
  output logic       reg_set,
  output logic       pc_select
);

  opcode_e op;
  assign op = opcode_e'(opcode);

  always_comb begin
    op_class  = CL_ALU;
    wr_lower  = 1'b0;
    wr_upper  = 1'b0;
    reg_set   = 1'b0;
    pc_select = 1'b0;
    if (is_alu_op(op)) begin
      op_class = CL_ALU;
      wr_lower = 1'b1;
      wr_upper = 1'b1;
    end else begin
      case (op)
        OP_JMP: begin
          op_class  = CL_BRANCH;
          pc_select = 1'b1;
        end
        OP_BRZ: begin
          op_class  = CL_BRANCH;
          pc_select = branch_zero;
        end
        OP_BRN: begin
          op_class  = CL_BRANCH;
          pc_select = branch_negative;
        end
        OP_HLT: op_class = CL_HALT;
        // Load write enables are only released by the controller in the
        // data_ready cycle of MEMORY.
        OP_LOD: begin
          op_class = CL_LOAD;
          wr_lower = 1'b1;
          wr_upper = 1'b1;
        end
        OP_STR: op_class = CL_STORE;
        OP_SEL: begin
          op_class = CL_SET;
          reg_set  = 1'b1;
          wr_lower = 1'b1;
        end
        OP_SEU: begin
          op_class = CL_SET;
          reg_set  = 1'b1;
          wr_upper = 1'b1;
        end
        default: op_class = CL_ALU;
      endcase
    end
  end

endmodule

// File: rtl/nbbpu_controller.sv
// rtl/nbbpu_controller.sv - multi-cycle fetch/execute/memory sequencer for the NBBPU datapath
//
// Purpose: fetches 16-bit instructions over a request/ready handshake,
// holds them in the instruction register, and sequences the datapath's
// register-write, set, PC-select and PC-enable controls. Loads and stores
// stall in MEMORY until data_ready. Counts retired instructions.
// Ports:
//   clock, reset (async, active low)
//   instr_data/instr_ready      instruction memory response
//   data_ready                  data memory access complete
//   branch_zero/branch_negative datapath flags
//   instr_req, data_read_req, data_write_req   memory requests
//   instruction                 instruction register to datapath
//   reg_write_lower/upper, reg_set, PC_select, pc_enable   datapath controls
//   halted, retired             status

module nbbpu_controller
  import nbbpu_pkg::*;
#(
  parameter int RETIRE_WIDTH = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [15:0]             instr_data,
  input  logic                    instr_ready,
  input  logic                    data_ready,
  input  logic                    branch_zero,
  input  logic                    branch_negative,
  output logic                    instr_req,
  output logic                    data_read_req,
  output logic                    data_write_req,
  output logic [15:0]             instruction,
  output logic                    reg_write_lower,
  output logic                    reg_write_upper,
  output logic                    reg_set,
  output logic                    PC_select,
  output logic                    pc_enable,
  output logic                    halted,
  output logic [RETIRE_WIDTH-1:0] retired
);

  state_e                  state_q, state_d;
  logic [15:0]             instr_q, instr_d;
  logic [RETIRE_WIDTH-1:0] retired_q, retired_d;
  logic                    retire_inc;

  class_e dec_class;
  logic   dec_wr_lower;
  logic   dec_wr_upper;
  logic   dec_reg_set;
  logic   dec_pc_select;

  nbbpu_decode u_decode (
    .opcode          (instr_q[15:12]),
    .branch_zero     (branch_zero),
    .branch_negative (branch_negative),
    .op_class        (dec_class),
    .wr_lower        (dec_wr_lower),
    .wr_upper        (dec_wr_upper),
    .reg_set         (dec_reg_set),
    .pc_select       (dec_pc_select)
  );

  always_comb begin
    state_d         = state_q;
    instr_d         = instr_q;
    retire_inc      = 1'b0;
    instr_req       = 1'b0;
    data_read_req   = 1'b0;
    data_write_req  = 1'b0;
    reg_write_lower = 1'b0;
    reg_write_upper = 1'b0;
    reg_set         = 1'b0;
    PC_select       = 1'b0;
    pc_enable       = 1'b0;
    halted          = 1'b0;

    case (state_q)
      ST_START: state_d = ST_FETCH;

      ST_FETCH: begin
        instr_req = 1'b1;
        if (instr_ready) begin
          instr_d = instr_data;
          state_d = ST_EXECUTE;
        end
      end

      ST_EXECUTE: begin
        case (dec_class)
          CL_LOAD, CL_STORE: state_d = ST_MEMORY;
          // HLT never pulses pc_enable, so it is counted on entry to HALT.
          CL_HALT: begin
            state_d    = ST_HALT;
            retire_inc = 1'b1;
          end
          default: begin
            reg_write_lower = dec_wr_lower;
            reg_write_upper = dec_wr_upper;
            reg_set         = dec_reg_set;
            PC_select       = dec_pc_select;
            pc_enable       = 1'b1;
            state_d         = ST_FETCH;
          end
        endcase
      end

      ST_MEMORY: begin
        data_read_req  = (dec_class == CL_LOAD);
        data_write_req = (dec_class == CL_STORE);
        if (data_ready) begin
          // Decode gives zero write enables for stores.
          pc_enable       = 1'b1;
          reg_write_lower = dec_wr_lower;
          reg_write_upper = dec_wr_upper;
          state_d         = ST_FETCH;
        end
      end

      ST_HALT: halted = 1'b1;

      default: state_d = ST_START;
    endcase

    if (pc_enable) begin
      retire_inc = 1'b1;
    end
    retired_d = retired_q + {{(RETIRE_WIDTH-1){1'b0}}, retire_inc};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_START;
      instr_q   <= 16'h0000;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  assign instruction = instr_q;
  assign retired     = retired_q;

endmodule

// File: doc/nbbpu_controller.md
# nbbpu_controller

Multi-cycle sequencer for the NBBPU datapath. Fetches 16-bit instructions over a ready/request handshake, holds them in an instruction register, and decodes the 4-bit opcode. Generates the datapath's register-write, set, PC-select and PC-enable controls, and stalls on data-memory loads and stores. Sits between the instruction/data memory ports and the datapath. Requires the datapath PC register to gain a `pc_enable` input.

## Interface
Parameters:
- RETIRE_WIDTH, 16, width of the retired-instruction counter

Ports:
- clock  in  1  rising-edge system clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- instr_data  in  16  instruction word from instruction memory
- instr_ready  in  1  instr_data valid this cycle
- data_ready  in  1  data access complete; read_data valid to the datapath this cycle
- branch_zero  in  1  datapath flag: operand register == 0
- branch_negative  in  1  datapath flag: operand register bit 15 set
- instr_req  out  1  instruction fetch request at current PC
- data_read_req  out  1  load request at datapath address
- data_write_req  out  1  store request (write_data at address)
- instruction  out  16  instruction register, drives datapath
- reg_write_lower  out  1  write register bits [7:0]
- reg_write_upper  out  1  write register bits [15:8]
- reg_set  out  1  select immediate byte as register input
- PC_select  out  1  1 = jump target, 0 = PC+2
- pc_enable  out  1  PC register loads PC_next this cycle
- halted  out  1  core stopped
- retired  out  RETIRE_WIDTH  instructions completed, wraps

## Operation
- Opcodes: ADD 0, SUB 1, AND 2, IOR 3, XOR 4, SHR 5, SHL 6, CMP 7, JMP 8, BRZ 9, BRN A, HLT B, LOD C, STR D, SEL E, SEU F.
- States: START, FETCH, EXECUTE, MEMORY, HALT. The reset state is START.
- START: one cycle, all outputs 0, then go to FETCH.
- FETCH: instr_req=1. On instr_ready, capture instr_data into instruction and go to EXECUTE. Otherwise hold.
- EXECUTE: outputs are decoded combinationally from instruction.
  - ALU ops 0–7: reg_write_lower=reg_write_upper=1, pc_enable=1, go to FETCH.
  - SEL: reg_set=1, reg_write_lower=1. SEU: reg_set=1, reg_write_upper=1. Both assert pc_enable and go to FETCH.
  - JMP: PC_select=1. BRZ: PC_select=branch_zero. BRN: PC_select=branch_negative. All three assert pc_enable, write nothing, go to FETCH.
  - LOD/STR: go to MEMORY with no pc_enable.
  - HLT: go to HALT with no pc_enable.
- MEMORY: data_read_req (LOD) or data_write_req (STR) is held at 1 until data_ready.
  - In the data_ready cycle: pc_enable=1; LOD also asserts reg_write_lower=reg_write_upper=1; then go to FETCH.
- HALT: halted=1 and all other control outputs 0. The state is sticky until reset.
- retired increments by 1 in every cycle with pc_enable=1, and on entry to HALT. It wraps modulo 2^RETIRE_WIDTH.
- instr_ready outside FETCH is ignored. data_ready outside MEMORY is ignored.

## Timing
- Reset values: every output is 0, instruction=0, retired=0, state=START. Reset clears state asynchronously; all requests drop in the same instant, including mid-FETCH and mid-MEMORY.
- First instr_req: the second rising edge after reset deasserts (START lasts one cycle).
- With zero-wait memory (ready returned in the request cycle):
  - ALU/SET/branch: 2 cycles per instruction.
  - LOD/STR: 3 cycles per instruction.
- Each wait cycle adds exactly 1 cycle. The request stays asserted and stable for every wait cycle.
- Controls are Moore in state plus the registered instruction. pc_enable and write enables in MEMORY are additionally gated by data_ready. Neither has a combinational path from instr_data.
- The PC updates and the register write commits on the same edge that leaves EXECUTE or MEMORY.
- Requests deassert in the cycle after the ready is accepted.

## Structure
- nbbpu_pkg: opcode localparams/enum and controller state enum, shared with the ALU and testbenches.
- Sub-module nbbpu_decode: combinational opcode-to-control decode (class: alu/set/branch/load/store/halt, write masks, reg_set), used by the EXECUTE and MEMORY states.
- Top level contains the FSM, instruction register and retired counter.

## Test plan
- Reset release, instr_ready tied 1, instr_data=0x0123 (ADD) → instr_req high on cycle 2; EXECUTE in cycle 3 with both writes=1 and pc_enable=1; retired=1 after that edge.
- SEL 0xE4A2 → reg_set=1, reg_write_lower=1, reg_write_upper=0 for one cycle. SEU 0xF4A2 → reg_set=1, only reg_write_upper=1.
- BRZ 0x9123 with branch_zero=0 → PC_select=0, pc_enable=1. Repeat with branch_zero=1 → PC_select=1. JMP 0x8100 → PC_select=1 regardless of flags.
- LOD 0xC105 with data_ready delayed 3 cycles → data_read_req high exactly 4 cycles, writes and pc_enable only in the data_ready cycle. STR 0xD105 → data_write_req behaves the same with no writes.
- reset pulled low mid-MEMORY with data_write_req=1 → all outputs 0 immediately. After release: START, then a fetch of a fresh instruction.
- HLT 0xB000 → halted=1 permanently and instr_req stays 0 for 100 cycles. retired drives 0xFFFF→0x0000 wrap under a 65536-instruction ADD stream.
